// File: rtl/fpga_io_pkg.sv
// Shared constants for the Caravel pad bridge: register offsets, ID magic
// and the byte-lane helper used by the Wishbone write path.
package fpga_io_pkg;

   localparam int          MAX_PADS = 64;
   localparam logic [15:0] ID_MAGIC = 16'hF10B;

   localparam logic [7:0] REG_OEB_LO     = 8'h00;
   localparam logic [7:0] REG_OEB_HI     = 8'h04;
   localparam logic [7:0] REG_OVR_EN_LO  = 8'h08;
   localparam logic [7:0] REG_OVR_EN_HI  = 8'h0C;
   localparam logic [7:0] REG_OVR_VAL_LO = 8'h10;
   localparam logic [7:0] REG_OVR_VAL_HI = 8'h14;
   localparam logic [7:0] REG_PAD_IN_LO  = 8'h18;
   localparam logic [7:0] REG_PAD_IN_HI  = 8'h1C;
   localparam logic [7:0] REG_EDGE_LO    = 8'h20;
   localparam logic [7:0] REG_EDGE_HI    = 8'h24;
   localparam logic [7:0] REG_ID         = 8'h28;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/fpga_io_bridge_if.sv
// Wishbone slave bundle shared by the pad bridge and the configuration loader.
interface fpga_io_bridge_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/pad_sync.sv
// Parametrised-width two-flop synchroniser for raw pad inputs, async reset to 0.
module pad_sync #(
   parameter int WIDTH = 1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end
endmodule

// File: rtl/fpga_io_bridge.sv
// Wishbone-programmable bridge between Caravel pads and the fpga core GPIO.
// Define FPGA_IO_EDGE_CAPTURE_EN to build the sticky rising-edge (EDGE) registers.
module fpga_io_bridge
   import fpga_io_pkg::*;
#(
   parameter int          N_PADS    = 38,
   parameter logic [31:0] BASE_ADDR = 32'h3100_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   fpga_io_bridge_if.slave   wb,
   input  logic [N_PADS-1:0] io_in,
   output logic [N_PADS-1:0] io_out,
   output logic [N_PADS-1:0] io_oeb,
   input  logic [N_PADS-1:0] fpga_out,
   output logic [N_PADS-1:0] fpga_in
);
   localparam logic [63:0] PAD_MASK = {64{1'b1}} >> (MAX_PADS - N_PADS);

   logic              in_window, req, start, wr;
   logic [7:0]        off;
   logic [31:0]       wmask, rd_data, dat_q;
   logic              ack_q;
   logic [63:0]       oeb_r, ovr_en_r, ovr_val_r, pad_in64, edge_q;
   logic [N_PADS-1:0] sync_q, io_out_q, io_oeb_q;
   logic              unused_adr;

   function automatic logic [63:0] wr_merge(input logic [63:0] cur, input logic hi,
                                            input logic [31:0] d, input logic [31:0] m);
      logic [63:0] r;
      r = cur;
      if (hi) r[63:32] = (cur[63:32] & ~m) | (d & m);
      else    r[31:0]  = (cur[31:0]  & ~m) | (d & m);
      return r;
   endfunction

   assign in_window  = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
   assign req        = wb.wbs_stb_i & wb.wbs_cyc_i & in_window;
   assign start      = req & ~ack_q;
   assign wr         = start & wb.wbs_we_i;
   assign off        = {wb.wbs_adr_i[7:2], 2'b00};
   assign wmask      = lane_mask(wb.wbs_sel_i);
   assign pad_in64   = 64'(sync_q);
   assign unused_adr = ^wb.wbs_adr_i[1:0];

   pad_sync #(.WIDTH(N_PADS)) u_sync (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .d        (io_in),
      .q        (sync_q)
   );

   // Bit offset 2 separates every _HI word from its _LO partner.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         oeb_r     <= PAD_MASK;
         ovr_en_r  <= '0;
         ovr_val_r <= '0;
      end else if (wr) begin
         case (off)
            REG_OEB_LO, REG_OEB_HI:
               oeb_r <= wr_merge(oeb_r, off[2], wb.wbs_dat_i, wmask) & PAD_MASK;
            REG_OVR_EN_LO, REG_OVR_EN_HI:
               ovr_en_r <= wr_merge(ovr_en_r, off[2], wb.wbs_dat_i, wmask) & PAD_MASK;
            REG_OVR_VAL_LO, REG_OVR_VAL_HI:
               ovr_val_r <= wr_merge(ovr_val_r, off[2], wb.wbs_dat_i, wmask) & PAD_MASK;
            default: ;
         endcase
      end
   end

`ifdef FPGA_IO_EDGE_CAPTURE_EN
   logic [N_PADS-1:0] prev_q;
   logic [63:0]       edge_clr;

   always_comb begin
      edge_clr = '0;
      if (wr && off == REG_EDGE_LO) edge_clr[31:0]  = wb.wbs_dat_i & wmask;
      if (wr && off == REG_EDGE_HI) edge_clr[63:32] = wb.wbs_dat_i & wmask;
   end

   // A new edge wins over a same-cycle W1C clear.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         prev_q <= '0;
         edge_q <= '0;
      end else begin
         prev_q <= sync_q;
         edge_q <= ((edge_q & ~edge_clr) | 64'(sync_q & ~prev_q)) & PAD_MASK;
      end
   end
`else
   assign edge_q = '0;
`endif

   always_comb begin
      rd_data = '0;
      case (off)
         REG_OEB_LO:     rd_data = oeb_r[31:0];
         REG_OEB_HI:     rd_data = oeb_r[63:32];
         REG_OVR_EN_LO:  rd_data = ovr_en_r[31:0];
         REG_OVR_EN_HI:  rd_data = ovr_en_r[63:32];
         REG_OVR_VAL_LO: rd_data = ovr_val_r[31:0];
         REG_OVR_VAL_HI: rd_data = ovr_val_r[63:32];
         REG_PAD_IN_LO:  rd_data = pad_in64[31:0];
         REG_PAD_IN_HI:  rd_data = pad_in64[63:32];
         REG_EDGE_LO:    rd_data = edge_q[31:0];
         REG_EDGE_HI:    rd_data = edge_q[63:32];
         REG_ID:         rd_data = {ID_MAGIC, 8'd0, 8'(N_PADS)};
         default:        rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= start;
         dat_q <= start ? rd_data : '0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         io_out_q <= '0;
         io_oeb_q <= '1;
      end else begin
         io_out_q <= (ovr_en_r[N_PADS-1:0] & ovr_val_r[N_PADS-1:0])
                   | (~ovr_en_r[N_PADS-1:0] & fpga_out);
         io_oeb_q <= oeb_r[N_PADS-1:0];
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign io_out       = io_out_q;
   assign io_oeb       = io_oeb_q;
   assign fpga_in      = sync_q;
endmodule

// File: tb/tb_fpga_io_bridge.sv
// Self-checking bench for fpga_io_bridge: cycle model plus directed literal checks.
module tb_fpga_io_bridge;
   localparam int          NP   = 38;
   localparam logic [31:0] BASE = 32'h3100_0000;
   localparam logic [63:0] MASK = (64'd1 << NP) - 64'd1;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] io_in, io_out, io_oeb, fpga_out, fpga_in;
   logic          chk_en = 1'b0;
   int            tests = 0;
   int            fails = 0;

   fpga_io_bridge_if bus();

   fpga_io_bridge #(.N_PADS(NP), .BASE_ADDR(BASE)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb),
      .fpga_out (fpga_out),
      .fpga_in  (fpga_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0]   m_oeb, m_ovr_en, m_ovr_val, m_edge;
   logic [NP-1:0] hist [4];
   logic          m_ack;
   logic [31:0]   m_dat;
   logic [NP-1:0] e_out, e_oeb, e_fin;

   function automatic logic [63:0] wmerge(input logic [63:0] cur, input logic hi,
                                          input logic [31:0] d, input logic [3:0] sel);
      logic [63:0] r;
      r = cur;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[(hi ? 32 : 0) + b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off);
      logic [63:0] p;
      p = 64'(e_fin);
      case (off)
         8'h00: return m_oeb[31:0];
         8'h04: return m_oeb[63:32];
         8'h08: return m_ovr_en[31:0];
         8'h0C: return m_ovr_en[63:32];
         8'h10: return m_ovr_val[31:0];
         8'h14: return m_ovr_val[63:32];
         8'h18: return p[31:0];
         8'h1C: return p[63:32];
         8'h20: return m_edge[31:0];
         8'h24: return m_edge[63:32];
         8'h28: return 32'hF10B_0026;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      logic        start;
      logic [7:0]  off;
      logic [63:0] rise, clr;
      if (rst) begin
         m_oeb = MASK; m_ovr_en = '0; m_ovr_val = '0; m_edge = '0;
         for (int i = 0; i < 4; i++) hist[i] = '0;
         m_ack = 1'b0; m_dat = '0;
         e_out = '0; e_oeb = '1; e_fin = '0;
      end else begin
         start = bus.wbs_stb_i && bus.wbs_cyc_i && (bus.wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
         off   = {bus.wbs_adr_i[7:2], 2'b00};
         m_dat = start ? model_read(off) : 32'h0;
         m_ack = start;
         for (int i = 0; i < NP; i++) e_out[i] = m_ovr_en[i] ? m_ovr_val[i] : fpga_out[i];
         e_oeb = m_oeb[NP-1:0];
         hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = io_in;
         e_fin = hist[1];
         rise  = 64'(hist[2] & ~hist[3]);
         clr   = '0;
         if (start && bus.wbs_we_i) begin
            case (off)
               8'h00, 8'h04: m_oeb     = wmerge(m_oeb, off[2], bus.wbs_dat_i, bus.wbs_sel_i) & MASK;
               8'h08, 8'h0C: m_ovr_en  = wmerge(m_ovr_en, off[2], bus.wbs_dat_i, bus.wbs_sel_i) & MASK;
               8'h10, 8'h14: m_ovr_val = wmerge(m_ovr_val, off[2], bus.wbs_dat_i, bus.wbs_sel_i) & MASK;
               8'h20, 8'h24: clr       = wmerge(64'd0, off[2], bus.wbs_dat_i, bus.wbs_sel_i);
               default: ;
            endcase
         end
`ifdef FPGA_IO_EDGE_CAPTURE_EN
         m_edge = ((m_edge & ~clr) | rise) & MASK;
`endif
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ack",     64'(bus.wbs_ack_o), 64'(m_ack));
         check("dat_o",   64'(bus.wbs_dat_o), 64'(m_dat));
         check("io_out",  64'(io_out),        64'(e_out));
         check("io_oeb",  64'(io_oeb),        64'(e_oeb));
         check("fpga_in", 64'(fpga_in),       64'(e_fin));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd, output int lat);
      bus.wbs_adr_i = adr; bus.wbs_we_i = we; bus.wbs_dat_i = d; bus.wbs_sel_i = sel;
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
      lat = 0;
      do begin
         step(1);
         lat++;
      end while (!bus.wbs_ack_o && lat < 8);
      if (!bus.wbs_ack_o) check("ack_timeout", 64'(bus.wbs_ack_o), 64'd1);
      rd = bus.wbs_dat_o;
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] rd;
      int          lat;
      wb_xfer(BASE + 32'(off), 1'b1, d, sel, rd, lat);
   endtask

   task automatic wb_read(input logic [7:0] off, output logic [31:0] rd, output int lat);
      wb_xfer(BASE + 32'(off), 1'b0, 32'h0, 4'hF, rd, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] edge_exp;
      int          lat;
`ifdef FPGA_IO_EDGE_CAPTURE_EN
      edge_exp = 32'h20;
`else
      edge_exp = 32'h0;
`endif
      rst = 1'b1;
      io_in = '0; fpga_out = '0;
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;
      step(3);
      chk_en = 1'b1;
      rst = 1'b0;
      step(1);
      check("rst_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
      check("rst_out", 64'(io_out), 64'd0);
      check("rst_ack", 64'(bus.wbs_ack_o), 64'd0);

      wb_read(8'h28, rd, lat);
      check("id_val", 64'(rd), 64'h0000_0000_F10B_0026);
      check("id_lat", 64'(lat), 64'd1);

      wb_write(8'h00, 32'h0, 4'b0011);
      step(1);
      check("oeb_sel", 64'(io_oeb), 64'(38'h3F_FFFF_0000));
      fpga_out = 38'h15;
      step(1);
      check("out_pass", 64'(io_out[4:0]), 64'h15);

      wb_write(8'h04, 32'hFFFF_FFEA, 4'hF);
      wb_read(8'h04, rd, lat);
      check("oeb_hi_mask", 64'(rd), 64'h2A);

      fpga_out = '0;
      wb_write(8'h08, 32'h1, 4'hF);
      wb_write(8'h10, 32'h1, 4'hF);
      step(1);
      check("ovr_on", 64'(io_out[0]), 64'd1);
      wb_write(8'h08, 32'h0, 4'hF);
      step(1);
      check("ovr_off", 64'(io_out[0]), 64'd0);
      fpga_out[0] = 1'b1;
      step(1);
      check("ovr_follow", 64'(io_out[0]), 64'd1);

      io_in[5] = 1'b1;
      step(1);
      check("sync_1cyc", 64'(fpga_in), 64'd0);
      step(1);
      check("sync_2cyc", 64'(fpga_in), 64'h20);
      step(1);
      wb_read(8'h20, rd, lat);
      check("edge_set", 64'(rd), 64'(edge_exp));
      wb_read(8'h18, rd, lat);
      check("pad_in", 64'(rd), 64'h20);
      wb_write(8'h20, 32'h20, 4'hF);
      wb_read(8'h20, rd, lat);
      check("edge_clr", 64'(rd), 64'd0);

      io_in[5] = 1'b0;
      step(4);
      io_in[5] = 1'b1;
      step(2);
      wb_write(8'h20, 32'h20, 4'hF);
      wb_read(8'h20, rd, lat);
      check("edge_clr_race", 64'(rd), 64'(edge_exp));

      bus.wbs_adr_i = BASE + 32'h100; bus.wbs_we_i = 1'b0;
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("oow_ack", 64'(bus.wbs_ack_o), 64'd0);
         check("oow_dat", 64'(bus.wbs_dat_o), 64'd0);
      end
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;

      wb_write(8'h30, 32'hFFFF_FFFF, 4'hF);
      wb_read(8'h30, rd, lat);
      check("hole_read", 64'(rd), 64'd0);
      wb_read(8'h00, rd, lat);
      check("hole_nochg", 64'(rd), 64'hFFFF_0000);

      bus.wbs_adr_i = BASE + 32'h08; bus.wbs_we_i = 1'b1;
      bus.wbs_dat_i = 32'h3; bus.wbs_sel_i = 4'hF;
      bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
      #3 rst = 1'b1;
      step(1);
      check("rst_mid_ack", 64'(bus.wbs_ack_o), 64'd0);
      bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
      step(1);
      rst = 1'b0;
      step(2);
      wb_read(8'h08, rd, lat);
      check("rst_mid_lost", 64'(rd), 64'd0);
      check("rst_mid_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
